// File: rtl/stage_mem.sv
// rtl/stage_mem.sv - memory-access stage: aligned loads/stores over a req/gnt/rvalid bus
module stage_mem #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [31:0] i_alu_result,
  input  logic [31:0] i_store_data,
  input  logic        i_mem_read,
  input  logic        i_mem_write,
  input  logic [2:0]  i_funct3,
  input  logic [4:0]  i_rd_addr,
  input  logic        i_rd_wren,
  output logic        o_dmem_req,
  output logic        o_dmem_we,
  output logic [31:0] o_dmem_addr,
  output logic [31:0] o_dmem_wdata,
  output logic [3:0]  o_dmem_bmask,
  input  logic        i_dmem_gnt,
  input  logic        i_dmem_rvalid,
  input  logic [31:0] i_dmem_rdata,
  output logic        o_valid,
  output logic [4:0]  o_rd_addr,
  output logic        o_rd_wren,
  output logic [31:0] o_wb_data,
  output logic        o_misalign,
  output logic        o_bus_err
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  state_t          state, state_next;
  logic [CW-1:0]   tmo_cnt;
  logic [31:0]     q_addr, q_sd;
  logic [2:0]      q_funct3;
  logic            q_load, q_store, q_rd_wren;
  logic [4:0]      q_rd_addr;

  logic            in_mem, in_half, in_word, in_misalign;
  logic            q_byte, q_half;
  logic [31:0]     st_wdata, ld_shift, ld_data;
  logic [3:0]      st_bmask;
  logic            tmo_hit, capture, ret, ret_rd_wren, ret_mis, ret_berr;
  logic [31:0]     ret_data;
  logic [4:0]      ret_rd_addr;

  // funct3[1:0] selects the access size; 11 and the unused encodings fall to word
  assign in_mem      = i_mem_read | i_mem_write;
  assign in_half     = (i_funct3[1:0] == 2'b01);
  assign in_word     = i_funct3[1];
  assign in_misalign = (in_half & i_alu_result[0]) | (in_word & (|i_alu_result[1:0]));

  assign q_byte = (q_funct3[1:0] == 2'b00);
  assign q_half = (q_funct3[1:0] == 2'b01);

  always_comb begin
    st_bmask = 4'b1111;
    st_wdata = q_sd;
    if (q_byte) begin
      st_bmask = 4'b0001 << q_addr[1:0];
      st_wdata = {4{q_sd[7:0]}};
    end else if (q_half) begin
      st_bmask = 4'b0011 << q_addr[1:0];
      st_wdata = {2{q_sd[15:0]}};
    end
  end

  assign ld_shift = i_dmem_rdata >> {q_addr[1:0], 3'b000};

  always_comb begin
    ld_data = i_dmem_rdata;
    if (q_byte)
      ld_data = {{24{ld_shift[7] & ~q_funct3[2]}}, ld_shift[7:0]};
    else if (q_half)
      ld_data = {{16{ld_shift[15] & ~q_funct3[2]}}, ld_shift[15:0]};
  end

  assign tmo_hit = (TIMEOUT_CYCLES != 0) && (int'(tmo_cnt) == TIMEOUT_CYCLES - 1);

  always_comb begin
    state_next  = state;
    capture     = 1'b0;
    ret         = 1'b0;
    ret_rd_wren = 1'b0;
    ret_mis     = 1'b0;
    ret_berr    = 1'b0;
    ret_data    = q_addr;
    ret_rd_addr = (state == S_IDLE) ? i_rd_addr : q_rd_addr;
    case (state)
      S_IDLE: begin
        if (i_valid) begin
          ret_data = i_alu_result;
          if (in_mem && in_misalign) begin
            ret     = 1'b1;
            ret_mis = 1'b1;
          end else if (in_mem) begin
            capture    = 1'b1;
            state_next = S_REQ;
          end else begin
            ret         = 1'b1;
            ret_rd_wren = i_rd_wren;
          end
        end
      end
      S_REQ: begin
        if (i_dmem_gnt) begin
          if (q_load) begin
            state_next = S_WAIT;
          end else begin
            ret        = 1'b1;
            state_next = S_IDLE;
          end
        end else if (tmo_hit) begin
          ret        = 1'b1;
          ret_berr   = 1'b1;
          state_next = S_IDLE;
        end
      end
      S_WAIT: begin
        if (i_dmem_rvalid) begin
          ret         = 1'b1;
          ret_rd_wren = q_rd_wren;
          ret_data    = ld_data;
          state_next  = S_IDLE;
        end else if (tmo_hit) begin
          ret        = 1'b1;
          ret_berr   = 1'b1;
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state     <= S_IDLE;
      tmo_cnt   <= '0;
      q_addr    <= '0;
      q_sd      <= '0;
      q_funct3  <= '0;
      q_load    <= 1'b0;
      q_store   <= 1'b0;
      q_rd_addr <= '0;
      q_rd_wren <= 1'b0;
    end else begin
      state <= state_next;
      if (state == S_IDLE || state_next != state)
        tmo_cnt <= '0;
      else
        tmo_cnt <= tmo_cnt + CW'(1);
      if (capture) begin
        q_addr    <= i_alu_result;
        q_sd      <= i_store_data;
        q_funct3  <= i_funct3;
        q_load    <= i_mem_read;
        q_store   <= i_mem_write & ~i_mem_read;
        q_rd_addr <= i_rd_addr;
        q_rd_wren <= i_rd_wren;
      end
    end
  end

  // retire bundle only moves on a retire so it holds between pulses
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_valid    <= 1'b0;
      o_rd_addr  <= '0;
      o_rd_wren  <= 1'b0;
      o_wb_data  <= '0;
      o_misalign <= 1'b0;
      o_bus_err  <= 1'b0;
    end else begin
      o_valid <= ret;
      if (ret) begin
        o_rd_addr  <= ret_rd_addr;
        o_rd_wren  <= ret_rd_wren;
        o_wb_data  <= ret_data;
        o_misalign <= ret_mis;
        o_bus_err  <= ret_berr;
      end
    end
  end

  assign o_ready      = (state == S_IDLE);
  assign o_dmem_req   = (state == S_REQ);
  assign o_dmem_we    = o_dmem_req & q_store;
  assign o_dmem_addr  = o_dmem_req ? {q_addr[31:2], 2'b00} : 32'h0;
  assign o_dmem_wdata = (o_dmem_req & q_store) ? st_wdata : 32'h0;
  assign o_dmem_bmask = !o_dmem_req ? 4'b0000 : (q_store ? st_bmask : 4'b1111);

endmodule

// File: tb/tb_stage_mem.sv
// tb/tb_stage_mem.sv - scoreboard bench for stage_mem
module tb_stage_mem;

  logic        i_clk = 1'b0;
  logic        i_reset, i_valid, i_mem_read, i_mem_write, i_rd_wren;
  logic [31:0] i_alu_result, i_store_data, i_dmem_rdata;
  logic [2:0]  i_funct3;
  logic [4:0]  i_rd_addr;
  logic        i_dmem_gnt, i_dmem_rvalid;
  logic        o_ready, o_dmem_req, o_dmem_we, o_valid, o_rd_wren, o_misalign, o_bus_err;
  logic [31:0] o_dmem_addr, o_dmem_wdata, o_wb_data;
  logic [3:0]  o_dmem_bmask;
  logic [4:0]  o_rd_addr;

  typedef struct {
    logic [4:0]  rd_addr;
    logic        rd_wren;
    logic [31:0] data;
    logic        chk_data;
    logic        mis;
    logic        berr;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   req_cycles = 0;
  int   retired = 0;

  stage_mem #(.TIMEOUT_CYCLES(4)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_valid(i_valid), .o_ready(o_ready),
    .i_alu_result(i_alu_result), .i_store_data(i_store_data),
    .i_mem_read(i_mem_read), .i_mem_write(i_mem_write), .i_funct3(i_funct3),
    .i_rd_addr(i_rd_addr), .i_rd_wren(i_rd_wren),
    .o_dmem_req(o_dmem_req), .o_dmem_we(o_dmem_we), .o_dmem_addr(o_dmem_addr),
    .o_dmem_wdata(o_dmem_wdata), .o_dmem_bmask(o_dmem_bmask),
    .i_dmem_gnt(i_dmem_gnt), .i_dmem_rvalid(i_dmem_rvalid), .i_dmem_rdata(i_dmem_rdata),
    .o_valid(o_valid), .o_rd_addr(o_rd_addr), .o_rd_wren(o_rd_wren),
    .o_wb_data(o_wb_data), .o_misalign(o_misalign), .o_bus_err(o_bus_err)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got 0x%08h want 0x%08h", tag, obs, exp);
    end
  endtask

  always @(negedge i_clk) begin
    if (!i_reset) begin
      if (o_dmem_req) req_cycles++;
      if (o_valid) begin
        retired++;
        if (sb.size() == 0) begin
          check("spurious_valid", {31'b0, o_valid}, 32'h0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("rd_addr", {27'b0, o_rd_addr}, {27'b0, e.rd_addr});
          check("rd_wren", {31'b0, o_rd_wren}, {31'b0, e.rd_wren});
          check("misalign", {31'b0, o_misalign}, {31'b0, e.mis});
          check("bus_err", {31'b0, o_bus_err}, {31'b0, e.berr});
          if (e.chk_data) check("wb_data", o_wb_data, e.data);
        end
      end
    end
  end

  function automatic exp_t mk(logic [4:0] rd, logic wren, logic [31:0] d, logic cd, logic mis, logic berr);
    exp_t e;
    e.rd_addr = rd; e.rd_wren = wren; e.data = d; e.chk_data = cd; e.mis = mis; e.berr = berr;
    return e;
  endfunction

  task automatic cycle();
    @(posedge i_clk);
    #1;
  endtask

  task automatic accept(input logic [31:0] a, input logic [31:0] sd, input logic rd,
                        input logic wr, input logic [2:0] f3, input logic [4:0] rda);
    i_valid = 1'b1; i_alu_result = a; i_store_data = sd; i_mem_read = rd;
    i_mem_write = wr; i_funct3 = f3; i_rd_addr = rda; i_rd_wren = 1'b1;
    cycle();
    i_valid = 1'b0; i_mem_read = 1'b0; i_mem_write = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40 && !o_ready; i++) cycle();
    check("idle_reached", {31'b0, o_ready}, 32'h1);
    cycle();
  endtask

  task automatic do_store(input logic [31:0] a, input logic [2:0] f3, input logic [31:0] sd,
                          input int waits, input logic [3:0] bm, input logic [31:0] wd);
    int base;
    sb.push_back(mk(5'd5, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0));
    base = req_cycles;
    accept(a, sd, 1'b0, 1'b1, f3, 5'd5);
    check("st_req", {31'b0, o_dmem_req}, 32'h1);
    check("st_we", {31'b0, o_dmem_we}, 32'h1);
    check("st_addr", o_dmem_addr, {a[31:2], 2'b00});
    check("st_bmask", {28'b0, o_dmem_bmask}, {28'b0, bm});
    check("st_wdata", o_dmem_wdata, wd);
    repeat (waits) cycle();
    i_dmem_gnt = 1'b1;
    cycle();
    i_dmem_gnt = 1'b0;
    check("st_req_cycles", req_cycles - base, waits + 1);
    wait_idle();
  endtask

  task automatic do_load(input logic [31:0] a, input logic [2:0] f3, input logic [31:0] rdata,
                         input logic [31:0] exp_data);
    sb.push_back(mk(5'd7, 1'b1, exp_data, 1'b1, 1'b0, 1'b0));
    accept(a, 32'h0, 1'b1, 1'b0, f3, 5'd7);
    check("ld_we", {31'b0, o_dmem_we}, 32'h0);
    check("ld_addr", o_dmem_addr, {a[31:2], 2'b00});
    check("ld_bmask", {28'b0, o_dmem_bmask}, 32'hF);
    i_dmem_gnt = 1'b1;
    cycle();
    i_dmem_gnt = 1'b0;
    i_dmem_rvalid = 1'b1; i_dmem_rdata = rdata;
    cycle();
    i_dmem_rvalid = 1'b0;
    wait_idle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    i_reset = 1'b1; i_valid = 1'b0; i_mem_read = 1'b0; i_mem_write = 1'b0; i_rd_wren = 1'b0;
    i_alu_result = '0; i_store_data = '0; i_dmem_rdata = '0; i_funct3 = '0; i_rd_addr = '0;
    i_dmem_gnt = 1'b0; i_dmem_rvalid = 1'b0;
    repeat (3) cycle();
    i_reset = 1'b0;
    @(negedge i_clk);
    check("rst_ready", {31'b0, o_ready}, 32'h1);
    check("rst_valid", {31'b0, o_valid}, 32'h0);
    check("rst_req", {31'b0, o_dmem_req}, 32'h0);
    check("rst_wb", o_wb_data, 32'h0);
    cycle();

    // non-mem stream, back-to-back
    base = retired;
    for (int k = 1; k <= 3; k++) begin
      sb.push_back(mk(5'(k), 1'b1, 32'(k * 16), 1'b1, 1'b0, 1'b0));
      check("stream_ready", {31'b0, o_ready}, 32'h1);
      accept(32'(k * 16), 32'h0, 1'b0, 1'b0, 3'b010, 5'(k));
    end
    check("stream_ready_end", {31'b0, o_ready}, 32'h1);
    cycle();
    check("stream_count", retired - base, 3);

    do_store(32'h1003, 3'b000, 32'h0000_00A5, 2, 4'b1000, 32'hA5A5_A5A5);
    do_store(32'h1002, 3'b001, 32'h0000_1234, 0, 4'b1100, 32'h1234_1234);
    do_store(32'h1004, 3'b010, 32'hDEAD_BEEF, 1, 4'b1111, 32'hDEAD_BEEF);

    do_load(32'h2001, 3'b000, 32'h0000_80FF, 32'hFFFF_FF80);
    do_load(32'h2001, 3'b100, 32'h0000_80FF, 32'h0000_0080);
    do_load(32'h2002, 3'b101, 32'h8001_0000, 32'h0000_8001);
    do_load(32'h2002, 3'b001, 32'h8001_0000, 32'hFFFF_8001);
    do_load(32'h2004, 3'b010, 32'h1357_9BDF, 32'h1357_9BDF);

    // misaligned word load
    sb.push_back(mk(5'd9, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0));
    base = req_cycles;
    accept(32'h3002, 32'h0, 1'b1, 1'b0, 3'b010, 5'd9);
    check("mis_noreq", {31'b0, o_dmem_req}, 32'h0);
    cycle();
    check("mis_req_cycles", req_cycles - base, 0);
    cycle();

    // granted load whose rvalid never comes
    sb.push_back(mk(5'd11, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1));
    accept(32'h4000, 32'h0, 1'b1, 1'b0, 3'b010, 5'd11);
    i_dmem_gnt = 1'b1;
    cycle();
    i_dmem_gnt = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge i_clk);
      check("tmo_early", {31'b0, o_valid}, 32'h0);
      cycle();
    end
    @(negedge i_clk);
    check("tmo_valid", {31'b0, o_valid}, 32'h1);
    check("tmo_ready", {31'b0, o_ready}, 32'h1);
    cycle();

    // reset while waiting for read data
    base = retired;
    accept(32'h5000, 32'h0, 1'b1, 1'b0, 3'b010, 5'd13);
    i_dmem_gnt = 1'b1;
    cycle();
    i_dmem_gnt = 1'b0;
    i_reset = 1'b1;
    cycle();
    i_reset = 1'b0;
    i_dmem_rvalid = 1'b1; i_dmem_rdata = 32'hCAFE_F00D;
    cycle();
    i_dmem_rvalid = 1'b0;
    check("rst_wait_ready", {31'b0, o_ready}, 32'h1);
    repeat (3) cycle();
    check("rst_wait_noret", retired - base, 0);
    check("sb_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/stage_mem.md
Name: stage_mem

Overview:
- Memory-access stage directly downstream of the execute stage.
- Consumes the EX result (ALU result / link address) and the forwarded store data.
- Performs loads and stores over a request/grant/response data-memory bus, with byte-lane alignment and sign extension.
- Delivers a registered write-back bundle to the MEM/WB boundary and stalls upstream while a bus transaction is outstanding.

Parameters:
- TIMEOUT_CYCLES, 255, max cycles waiting in REQ or WAIT before aborting with bus error; 0 disables the timeout.

Ports:
- i_clk  in  1  clock.
- i_reset  in  1  synchronous active-high reset.
- i_valid  in  1  EX stage presents an instruction.
- o_ready  out  1  stage can accept; high only in IDLE.
- i_alu_result  in  32  address for load/store, write-back value otherwise.
- i_store_data  in  32  forwarded rs2.
- i_mem_read  in  1  load.
- i_mem_write  in  1  store.
- i_funct3  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU.
- i_rd_addr  in  5  destination register.
- i_rd_wren  in  1  destination write enable.
- o_dmem_req  out  1  bus request; held until grant.
- o_dmem_we  out  1  request is a write.
- o_dmem_addr  out  32  word-aligned address {addr[31:2],2'b00}.
- o_dmem_wdata  out  32  lane-replicated store data.
- o_dmem_bmask  out  4  byte-enable mask.
- i_dmem_gnt  in  1  request accepted this cycle.
- i_dmem_rvalid  in  1  read data valid.
- i_dmem_rdata  in  32  read word.
- o_valid  out  1  one-cycle pulse per retired instruction.
- o_rd_addr  out  5  destination register.
- o_rd_wren  out  1  destination write enable; 0 for stores and on any fault.
- o_wb_data  out  32  write-back data.
- o_misalign  out  1  misaligned access fault.
- o_bus_err  out  1  timeout fault.

Behaviour:
- Reset:
  - state=IDLE; all outputs 0; timeout counter 0.
  - Reset mid-transaction abandons the transaction.
  - An i_dmem_rvalid or i_dmem_gnt arriving after reset is ignored.
- States:
  - IDLE: o_ready=1. Acceptance is i_valid&o_ready. Instruction fields are captured into internal registers.
  - REQ: o_dmem_req=1 with stable addr/we/wdata/bmask. When i_dmem_gnt is sampled high:
    - store -> IDLE and retire.
    - load -> WAIT.
  - WAIT: when i_dmem_rvalid is sampled high -> IDLE and retire with the extracted load data. An rvalid in the same cycle as gnt is not legal; the bus guarantees rvalid no earlier than the cycle after gnt.
- Non-memory instruction (neither read nor write):
  - Stays in IDLE.
  - o_valid=1 next cycle with o_wb_data=i_alu_result.
  - Back-to-back acceptance every cycle.
- Read and write both set: treated as a load.
- Retire timing: o_valid and the output bundle are registered, asserted the cycle after the retiring event, held for one cycle. Outputs hold their last value while o_valid=0.
- Latency:
  - non-mem: 1 cycle.
  - store: accept + N grant-wait cycles + 1.
  - load: additionally waits for rvalid.
- Misalignment check at accept:
  - H/HU/SH faults when addr[0]!=0.
  - W/SW faults when addr[1:0]!=0.
  - On fault: no bus request; o_valid next cycle with o_misalign=1, o_rd_wren=0.
- Store lanes, with off=addr[1:0]:
  - SB: bmask=4'b0001<<off, wdata={4{sd[7:0]}}.
  - SH: bmask=4'b0011<<off, wdata={2{sd[15:0]}}.
  - SW: bmask=1111, wdata=sd.
- Load extract:
  - byte = rdata>>(8*off), then sign-extend (B) or zero-extend (BU) from bit 7.
  - halfword = rdata>>(8*off), then sign-extend (H) or zero-extend (HU) from bit 15.
  - W passes the word through.
  - Unlisted funct3 values decode as W.
- Loads always issue o_dmem_bmask=1111.
- Timeout:
  - Counter clears on entering REQ or WAIT and increments each cycle spent there.
  - When it reaches TIMEOUT_CYCLES (if nonzero), go to IDLE and retire with o_bus_err=1, o_rd_wren=0.
  - A gnt/rvalid in the same cycle as expiry wins over the timeout.
- o_ready is purely a function of state (no combinational path from bus inputs).

Test Plan:
- Reset then non-mem stream: three back-to-back i_valid with alu_result 0x10, 0x20, 0x30 -> o_valid on three consecutive cycles; o_wb_data 0x10, 0x20, 0x30; o_ready stays 1.
- SB at 0x1003 with store_data 0x000000A5, gnt after 2 wait cycles -> req held 3 cycles; addr 0x1000, bmask 1000, wdata 0xA5A5A5A5; then o_valid with rd_wren=0.
- LB at 0x2001 with rdata 0x0000_80FF -> o_wb_data 0xFFFFFF80. Same as LBU -> 0x00000080. LHU at 0x2002 with rdata 0x8001_0000 -> 0x00008001.
- LW at 0x3002 -> no o_dmem_req; o_valid next cycle with o_misalign=1, rd_wren=0.
- TIMEOUT_CYCLES=4, load granted but rvalid never arrives -> o_valid with o_bus_err=1 four cycles after WAIT entry; o_ready high the same cycle.
- Assert i_reset while in WAIT, then pulse rvalid -> no o_valid; state IDLE; o_ready=1 after reset.
